// File: rtl/rbuffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART receive-buffer frame
//            controller (state encoding, default geometry, pad byte, and a
//            saturating increment helper).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    PAD    = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int         FRAME_LEN_DEF = 5;
  localparam int         TIMEOUT_DEF   = 100000;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rbuffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rbuffer_ctrl_if
// Purpose  : Bundles the receiver input, buffer port and consumer stream of
//            the frame controller.
//   master : controller side (drives buffer write/address and output stream)
//   slave  : environment side (UART receiver, buffer memory, consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface rbuffer_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              buf_wr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_rdata;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              frame_err;
  logic              overrun;
  logic [7:0]        ovr_cnt;

  modport master (
    input  rx_done, rx_data, buf_rdata, out_ready,
    output buf_wr, buf_wdata, buf_addr, out_data, out_valid, out_last,
           frame_err, overrun, ovr_cnt
  );

  modport slave (
    output rx_done, rx_data, buf_rdata, out_ready,
    input  buf_wr, buf_wdata, buf_addr, out_data, out_valid, out_last,
           frame_err, overrun, ovr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rbuffer_ctrl_timeout.sv
`default_nettype none
// ============================================================================
// Module   : rbuffer_timeout
// Purpose  : Clearable idle counter. Counts enabled cycles and raises expire
//            combinationally during the cycle in which the count already
//            holds TIMEOUT-1 and counting is still enabled.
// Ports    : clk, reset (sync, active-high), clr (zero the count),
//            en (count this cycle), expire (timeout reached this cycle)
// Revision : 1.0 - initial release
// ============================================================================
module rbuffer_timeout #(
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic clr,
  input  wire logic en,
  output logic      expire
);
  localparam logic [TO_W-1:0] C_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = en && (r_cnt == C_LAST);
endmodule
`default_nettype wire

// File: rtl/rbuffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rbuffer_ctrl
// Purpose  : Collects FRAME_LEN received bytes into the buffer, then drains
//            them in order over valid/ready. A stalled partial frame is
//            padded to full length and reported with frame_err. Bytes that
//            arrive while padding, committing or draining are dropped and
//            counted.
// Ports    : clk, reset (sync, active-high), bus (rbuffer_ctrl_if.master)
// Revision : 1.0 - initial release
// ============================================================================
module rbuffer_ctrl
  import uart_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADDR_W    = 3,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TO_W      = 17
) (
  input  wire logic      clk,
  input  wire logic      reset,
  rbuffer_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] C_PREV_IDX = ADDR_W'(FRAME_LEN - 2);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_buf_wr;
  logic [7:0]        r_buf_wdata;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_frame_err;
  logic              r_overrun;
  logic [7:0]        r_ovr_cnt;

  logic w_to_en;
  logic w_expire;
  logic w_last_slot;
  logic w_drop;

  // Idle time is only measured inside a partial frame; any received byte
  // restarts it, so a byte coinciding with expiry cancels the timeout.
  assign w_to_en     = (r_state == RECV) && (r_wr_cnt != '0) && !bus.rx_done;
  assign w_last_slot = (r_wr_cnt == C_LAST_IDX);
  assign w_drop      = bus.rx_done && (r_state != RECV);

  rbuffer_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (!w_to_en),
    .en     (w_to_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RECV;
      r_wr_cnt    <= '0;
      r_rd_idx    <= '0;
      r_buf_wr    <= 1'b0;
      r_buf_wdata <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_ovr_cnt   <= 8'h00;
    end else begin
      r_buf_wr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      if (w_drop) begin
        r_overrun <= 1'b1;
        r_ovr_cnt <= sat_inc8(r_ovr_cnt);
      end

      case (r_state)
        RECV: begin
          if (bus.rx_done) begin
            r_buf_wr    <= 1'b1;
            r_buf_wdata <= bus.rx_data;
            r_wr_cnt    <= r_wr_cnt + 1'b1;
            if (w_last_slot) r_state <= COMMIT;
          end else if (w_expire) begin
            r_state <= PAD;
          end
        end

        // Fill the remaining slots so the buffer's write pointer lands back
        // on a frame boundary.
        PAD: begin
          r_buf_wr    <= 1'b1;
          r_buf_wdata <= PAD_BYTE;
          if (w_last_slot) begin
            r_frame_err <= 1'b1;
            r_wr_cnt    <= '0;
            r_state     <= RECV;
          end else begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
          end
        end

        // Gap cycle: the final byte's write lands before the first read.
        COMMIT: begin
          r_rd_idx    <= '0;
          r_out_valid <= 1'b1;
          r_out_last  <= (FRAME_LEN == 1);
          r_state     <= DRAIN;
        end

        DRAIN: begin
          if (bus.out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_rd_idx    <= '0;
              r_wr_cnt    <= '0;
              r_state     <= RECV;
            end else begin
              r_rd_idx   <= r_rd_idx + 1'b1;
              r_out_last <= (r_rd_idx == C_PREV_IDX);
            end
          end
        end

        default: r_state <= RECV;
      endcase
    end
  end

  assign bus.buf_wr    = r_buf_wr;
  assign bus.buf_wdata = r_buf_wdata;
  assign bus.buf_addr  = r_rd_idx;
  assign bus.out_data  = bus.buf_rdata;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.ovr_cnt   = r_ovr_cnt;
endmodule
`default_nettype wire

// File: tb/tb_rbuffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbuffer_ctrl
// Purpose  : Self-checking bench for rbuffer_ctrl. A queue-based frame model
//            predicts every registered output each cycle; directed scenarios
//            add hand-computed expectations; a random phase follows.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rbuffer_ctrl;
  localparam int FL = 5;
  localparam int AW = 3;
  localparam int TO = 16;
  localparam int TW = 5;

  localparam int P_COLLECT = 0;
  localparam int P_PAD     = 1;
  localparam int P_COMMIT  = 2;
  localparam int P_DRAIN   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rbuffer_ctrl_if #(.ADDR_W(AW)) bus();

  rbuffer_ctrl #(
    .FRAME_LEN (FL),
    .ADDR_W    (AW),
    .TIMEOUT   (TO),
    .TO_W      (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Buffer memory: own write pointer, wraps every frame, combinational read.
  logic [7:0] mem [FL];
  int         wptr;
  always @(posedge clk) begin
    if (reset) begin
      wptr <= 0;
    end else if (bus.buf_wr) begin
      mem[wptr] <= bus.buf_wdata;
      wptr      <= (wptr == FL - 1) ? 0 : wptr + 1;
    end
  end
  assign bus.buf_rdata = (32'(bus.buf_addr) < FL) ? mem[bus.buf_addr] : 8'h00;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         ph = P_COLLECT;
  int         idle_n = 0;
  logic [7:0] q[$];
  logic       e_wr = 1'b0, e_valid = 1'b0, e_last = 1'b0, e_err = 1'b0, e_ovr = 1'b0;
  logic [7:0] e_wdata = 8'h00, e_ovr_cnt = 8'h00;

  // Observations of the DUT
  logic [7:0] got[$];
  int n_wr = 0, n_err = 0, n_ovr = 0, n_valid = 0, n_last = 0;
  logic [7:0] last_byte = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    e_wr  = 1'b0;
    e_err = 1'b0;
    e_ovr = 1'b0;
    if (reset) begin
      q.delete();
      ph        = P_COLLECT;
      idle_n    = 0;
      e_wdata   = 8'h00;
      e_valid   = 1'b0;
      e_last    = 1'b0;
      e_ovr_cnt = 8'h00;
    end else begin
      if (bus.rx_done && ph != P_COLLECT) begin
        e_ovr = 1'b1;
        if (e_ovr_cnt != 8'hFF) e_ovr_cnt = e_ovr_cnt + 8'd1;
      end
      case (ph)
        P_COLLECT: begin
          if (bus.rx_done) begin
            q.push_back(bus.rx_data);
            e_wr    = 1'b1;
            e_wdata = bus.rx_data;
            idle_n  = 0;
            if (q.size() == FL) ph = P_COMMIT;
          end else if (q.size() != 0) begin
            idle_n++;
            if (idle_n == TO) begin
              ph     = P_PAD;
              idle_n = 0;
            end
          end
        end
        P_PAD: begin
          q.push_back(8'h00);
          e_wr    = 1'b1;
          e_wdata = 8'h00;
          if (q.size() == FL) begin
            e_err = 1'b1;
            q.delete();
            ph = P_COLLECT;
          end
        end
        P_COMMIT: begin
          ph      = P_DRAIN;
          e_valid = 1'b1;
          e_last  = (q.size() == 1);
        end
        default: begin
          if (bus.out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
              ph      = P_COLLECT;
              e_valid = 1'b0;
              e_last  = 1'b0;
            end else begin
              e_last = (q.size() == 1);
            end
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    chk("buf_wr",    32'(bus.buf_wr),    32'(e_wr));
    chk("buf_wdata", 32'(bus.buf_wdata), 32'(e_wdata));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("out_last",  32'(bus.out_last),  32'(e_last));
    chk("frame_err", 32'(bus.frame_err), 32'(e_err));
    chk("overrun",   32'(bus.overrun),   32'(e_ovr));
    chk("ovr_cnt",   32'(bus.ovr_cnt),   32'(e_ovr_cnt));
    if (e_valid && q.size() != 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0]));
      chk("buf_addr", 32'(bus.buf_addr), 32'(FL - q.size()));
    end
  endtask

  // One clock: apply inputs, note what the DUT presents this cycle, advance
  // the model, then compare just after the edge.
  task automatic tick(input logic rd, input logic [7:0] d);
    bus.rx_done = rd;
    bus.rx_data = d;
    if (!reset && bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      if (bus.out_last) begin
        n_last++;
        last_byte = bus.out_data;
      end
    end
    if (bus.buf_wr)    n_wr++;
    if (bus.frame_err) n_err++;
    if (bus.overrun)   n_ovr++;
    if (bus.out_valid) n_valid++;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] f [FL], input int n);
    for (int i = 0; i < n; i++) tick(1'b1, f[i]);
  endtask

  task automatic check_frame(input string nm, input int base, input logic [7:0] e [FL]);
    chk({nm, "_len"}, 32'(got.size() - base), 32'(FL));
    for (int i = 0; i < FL; i++)
      if (base + i < got.size()) chk(nm, 32'(got[base + i]), 32'(e[i]));
  endtask

  logic [7:0] f [FL];
  int b_got, b_wr, b_err, b_ovr, b_valid, b_last;
  int p;

  initial begin
    for (int i = 0; i < FL; i++) mem[i] = 8'h00;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    idle(3);
    reset = 1'b0;
    chk("rst_buf_wr",    32'(bus.buf_wr),    32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ovr_cnt",   32'(bus.ovr_cnt),   32'd0);
    chk("rst_buf_addr",  32'(bus.buf_addr),  32'd0);

    // 1: full frame, consumer always ready, latency pinned
    f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    b_got = got.size(); b_wr = n_wr; b_last = n_last;
    send(f, FL);
    chk("t1_wr_after_last",     32'(bus.buf_wr),    32'd1);
    chk("t1_valid_not_yet",     32'(bus.out_valid), 32'd0);
    tick(1'b0, 8'h00);
    chk("t1_valid_at_n2",       32'(bus.out_valid), 32'd1);
    chk("t1_first_data",        32'(bus.out_data),  32'h11);
    idle(8);
    check_frame("t1_frame", b_got, f);
    chk("t1_wr_pulses",  32'(n_wr - b_wr),     32'd5);
    chk("t1_last_count", 32'(n_last - b_last), 32'd1);
    chk("t1_last_byte",  32'(last_byte),       32'h55);

    // 2: consumer toggles ready
    b_got = got.size();
    send(f, FL);
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = ~bus.out_ready;
      tick(1'b0, 8'h00);
    end
    bus.out_ready = 1'b1;
    idle(2);
    check_frame("t2_frame", b_got, f);
    chk("t2_back_idle", 32'(bus.out_valid), 32'd0);

    // 3: partial frame times out and is padded
    b_wr = n_wr; b_err = n_err; b_valid = n_valid;
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    idle(TO + 10);
    chk("t3_wr_pulses", 32'(n_wr - b_wr),       32'd5);
    chk("t3_frame_err", 32'(n_err - b_err),     32'd1);
    chk("t3_no_valid",  32'(n_valid - b_valid), 32'd0);
    chk("t3_mem1",      32'(mem[1]),            32'hBB);
    chk("t3_pad2",      32'(mem[2]),            32'h00);
    chk("t3_pad4",      32'(mem[4]),            32'h00);
    f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    b_got = got.size();
    send(f, FL);
    idle(8);
    check_frame("t3_frame", b_got, f);

    // 4: bytes dropped while draining
    bus.out_ready = 1'b0;
    f = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    b_got = got.size(); b_wr = n_wr; b_ovr = n_ovr;
    send(f, FL);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'hE0 + 8'(i));
      tick(1'b0, 8'h00);
    end
    idle(1);
    chk("t4_ovr_cnt",    32'(bus.ovr_cnt),   32'd3);
    chk("t4_ovr_pulses", 32'(n_ovr - b_ovr), 32'd3);
    chk("t4_wr_pulses",  32'(n_wr - b_wr),   32'd5);
    bus.out_ready = 1'b1;
    idle(8);
    check_frame("t4_frame", b_got, f);

    // 5: reset mid-frame
    tick(1'b1, 8'h31);
    tick(1'b1, 8'h32);
    tick(1'b1, 8'h33);
    reset = 1'b1;
    tick(1'b0, 8'h00);
    chk("t5_rst_buf_wr",    32'(bus.buf_wr),    32'd0);
    chk("t5_rst_wdata",     32'(bus.buf_wdata), 32'd0);
    chk("t5_rst_valid",     32'(bus.out_valid), 32'd0);
    chk("t5_rst_ovr_cnt",   32'(bus.ovr_cnt),   32'd0);
    chk("t5_rst_frame_err", 32'(bus.frame_err), 32'd0);
    reset = 1'b0;
    f = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    b_got = got.size();
    send(f, FL);
    idle(8);
    check_frame("t5_frame", b_got, f);

    // 6: byte arrives on the final idle cycle before expiry
    b_err = n_err;
    tick(1'b1, 8'h71);
    idle(TO - 1);
    tick(1'b1, 8'h72);
    chk("t6_byte_written", 32'(bus.buf_wr), 32'd1);
    tick(1'b1, 8'h73);
    tick(1'b1, 8'h74);
    b_got = got.size();
    tick(1'b1, 8'h75);
    idle(8);
    f = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    check_frame("t6_frame", b_got, f);
    chk("t6_no_frame_err", 32'(n_err - b_err), 32'd0);

    // Random traffic with varying byte density (dense, sparse, very sparse)
    p = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       p = 50;
          1:       p = 6;
          default: p = 2;
        endcase
      end
      reset         = ($urandom_range(0, 399) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 99) < p, 8'($urandom_range(0, 255)));
    end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
